// File: rtl/accum_ctrl_sched_if.sv
// accum_ctrl_sched_if: systolic-array row handshake, accumulator controls and drain handshake
interface accum_ctrl_sched_if;
  logic sa_valid;
  logic sa_ready;
  logic acc_enable;
  logic acc_mode;
  logic acc_buf_sel;
  logic drain_valid;
  logic drain_buf;
  logic drain_ready;
  modport master (
    input  sa_valid, drain_ready,
    output sa_ready, acc_enable, acc_mode, acc_buf_sel, drain_valid, drain_buf
  );
  modport slave (
    output sa_valid, drain_ready,
    input  sa_ready, acc_enable, acc_mode, acc_buf_sel, drain_valid, drain_buf
  );
endinterface

// File: rtl/accum_ctrl_sched.sv
// accum_ctrl_sched: ping-pong accumulator sequencer with drain handoff; ACCUM_CTRL_PERF_EN adds a stall counter
module accum_ctrl_sched #(
  parameter int ROWS = 2,
  parameter int K_W  = 8,
  parameter int B_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K_W-1:0] num_k_tiles,
  input  logic [B_W-1:0] num_blocks,
  accum_ctrl_sched_if.master bus,
  output logic           busy,
  output logic           done
`ifdef ACCUM_CTRL_PERF_EN
  , output logic [31:0]  perf_stall_cycles
`endif
);
  localparam int R_W = ROWS > 1 ? $clog2(ROWS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t         state;
  logic [R_W-1:0] row_cnt;
  logic [K_W-1:0] tile_cnt, k_lat;
  logic [B_W-1:0] blk_cnt, nb_lat;
  logic           wr_buf, drain_ptr;
  logic [1:0]     full, full_n;
  logic           rel, last_row, last_tile, blk_end, last_blk;
  assign bus.sa_ready    = state == RUN && !full[wr_buf];
  assign bus.acc_enable  = bus.sa_valid && bus.sa_ready;
  assign bus.acc_mode    = tile_cnt != '0;
  assign bus.acc_buf_sel = wr_buf;
  assign bus.drain_valid = full[drain_ptr];
  assign bus.drain_buf   = drain_ptr;
  assign rel       = bus.drain_valid && bus.drain_ready;
  assign last_row  = row_cnt == R_W'(ROWS - 1);
  assign last_tile = tile_cnt == k_lat - 1'b1;
  assign blk_end   = bus.acc_enable && last_row && last_tile;
  assign last_blk  = blk_cnt == nb_lat - 1'b1;
  // Release and completion never target the same bit: completion needs full[wr_buf]==0, release needs full[drain_ptr]==1
  always_comb begin
    full_n = full;
    if (rel) full_n[drain_ptr] = 1'b0;
    if (blk_end) full_n[wr_buf] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      tile_cnt  <= '0;
      blk_cnt   <= '0;
      k_lat     <= '0;
      nb_lat    <= '0;
      wr_buf    <= 1'b0;
      drain_ptr <= 1'b0;
      full      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ACCUM_CTRL_PERF_EN
      perf_stall_cycles <= '0;
`endif
    end else begin
      done <= 1'b0;
      full <= full_n;
      if (rel) drain_ptr <= ~drain_ptr;
      if (bus.acc_enable) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        if (last_row) tile_cnt <= last_tile ? '0 : tile_cnt + 1'b1;
      end
      if (blk_end) begin
        wr_buf  <= ~wr_buf;
        blk_cnt <= blk_cnt + 1'b1;
      end
`ifdef ACCUM_CTRL_PERF_EN
      if (state == RUN && bus.sa_valid && !bus.sa_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
`endif
      case (state)
        IDLE: if (start) begin
          k_lat     <= num_k_tiles == '0 ? K_W'(1) : num_k_tiles;
          nb_lat    <= num_blocks;
          row_cnt   <= '0;
          tile_cnt  <= '0;
          blk_cnt   <= '0;
          wr_buf    <= 1'b0;
          drain_ptr <= 1'b0;
          full      <= '0;
          state     <= num_blocks != '0 ? RUN : DONE;
          busy      <= num_blocks != '0;
          done      <= num_blocks == '0;
`ifdef ACCUM_CTRL_PERF_EN
          perf_stall_cycles <= '0;
`endif
        end
        RUN: if (blk_end && last_blk) state <= FLUSH;
        FLUSH: if (full_n == '0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
